// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC channel scheduler.
//   CORDIC_LAT : default CORDIC latency in ce-edges (operand sampling to result)
//   CORDIC_PW  : default phase width (full circle = 2^CORDIC_PW)
//   tag_t      : {valid, ch} tag that travels alongside each operand
package cordic_pkg;
  localparam int CORDIC_LAT = 17;
  localparam int CORDIC_PW  = 19;
  // Sized for the largest supported channel count (8).
  localparam int TAG_CHW    = 3;

  typedef struct packed {
    logic               valid;
    logic [TAG_CHW-1:0] ch;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after i_ptr.
//   i_en    : grants are forced low when deasserted
//   i_req   : per-requester request
//   i_ptr   : last granted requester; the search starts at i_ptr+1
//   o_grant : one-hot grant (all zero when idle or disabled), combinational
module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            i_en,
  input  logic [NCH-1:0]  i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NCH-1:0]  o_grant
);
  logic            found;
  logic [PTRW-1:0] idx;

  always_comb begin
    o_grant = '0;
    found   = 1'b0;
    idx     = '0;
    // i runs 1..NCH so the last-granted requester is visited last.
    for (int i = 1; i <= NCH; i++) begin
      idx = PTRW'((int'(i_ptr) + i) % NCH);
      if (i_en && !found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cordic_channel_scheduler.sv
// Time-multiplexes one shared CORDIC among NCH channels.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_stall              : freezes the scheduler and (via o_cordic_ce) the CORDIC
//   i_req_valid/o_req_ready, i_req_x/y/phase : per-channel request, packed by channel
//   o_cordic_ce/x/y/phase: registered operands to the CORDIC
//   i_cordic_x/y         : CORDIC results, aligned with the last tag stage
//   o_res_valid/ch/x/y   : one-cycle result strobe with originating channel
//   o_inflight           : accepted but not yet returned operations
module cordic_channel_scheduler
  import cordic_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int IW  = 12,
  parameter  int PW  = CORDIC_PW,
  parameter  int OW  = 12,
  parameter  int LAT = CORDIC_LAT,
  localparam int CHW = $clog2(NCH),
  localparam int IFW = $clog2(LAT + 2)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall,
  input  logic [NCH-1:0]    i_req_valid,
  output logic [NCH-1:0]    o_req_ready,
  input  logic [NCH*IW-1:0] i_req_x,
  input  logic [NCH*IW-1:0] i_req_y,
  input  logic [NCH*PW-1:0] i_req_phase,
  output logic              o_cordic_ce,
  output logic [IW-1:0]     o_cordic_x,
  output logic [IW-1:0]     o_cordic_y,
  output logic [PW-1:0]     o_cordic_phase,
  input  logic [OW-1:0]     i_cordic_x,
  input  logic [OW-1:0]     i_cordic_y,
  output logic              o_res_valid,
  output logic [CHW-1:0]    o_res_ch,
  output logic [OW-1:0]     o_res_x,
  output logic [OW-1:0]     o_res_y,
  output logic [IFW-1:0]    o_inflight
);
  logic [CHW-1:0] ptr;
  logic [NCH-1:0] grant;
  logic [CHW-1:0] acc_ch;
  logic           accept;
  tag_t           new_tag;
  // Stage 0 is loaded with the operand; stage LAT lines up with i_cordic_x/y.
  tag_t [LAT:0]   tag_pipe;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_en   (!i_stall && !i_reset),
    .i_req  (i_req_valid),
    .i_ptr  (ptr),
    .o_grant(grant)
  );

  // Grants are only ever issued to valid channels, so any grant is an acceptance.
  assign o_req_ready = grant;
  assign accept      = |grant;
  assign o_cordic_ce = !i_stall;

  always_comb begin
    acc_ch = '0;
    for (int k = 0; k < NCH; k++)
      if (grant[k]) acc_ch = CHW'(k);
  end

  always_comb begin
    new_tag       = '0;
    new_tag.valid = accept;
    new_tag.ch    = TAG_CHW'(acc_ch);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr            <= CHW'(NCH - 1);
      tag_pipe       <= '0;
      o_cordic_x     <= '0;
      o_cordic_y     <= '0;
      o_cordic_phase <= '0;
      o_res_valid    <= 1'b0;
      o_res_ch       <= '0;
      o_res_x        <= '0;
      o_res_y        <= '0;
      o_inflight     <= '0;
    end else if (!i_stall) begin
      tag_pipe <= {tag_pipe[LAT-1:0], new_tag};
      if (accept) begin
        ptr            <= acc_ch;
        o_cordic_x     <= i_req_x[int'(acc_ch)*IW +: IW];
        o_cordic_y     <= i_req_y[int'(acc_ch)*IW +: IW];
        o_cordic_phase <= i_req_phase[int'(acc_ch)*PW +: PW];
      end else begin
        // Bubbles feed zeros so the CORDIC never sees stale operands.
        o_cordic_x     <= '0;
        o_cordic_y     <= '0;
        o_cordic_phase <= '0;
      end
      o_res_valid <= tag_pipe[LAT].valid;
      if (tag_pipe[LAT].valid) begin
        o_res_ch <= tag_pipe[LAT].ch[CHW-1:0];
        o_res_x  <= i_cordic_x;
        o_res_y  <= i_cordic_y;
      end
      case ({accept, tag_pipe[LAT].valid})
        2'b10:   o_inflight <= o_inflight + IFW'(1);
        2'b01:   o_inflight <= o_inflight - IFW'(1);
        default: ;
      endcase
    end else begin
      o_res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cordic_channel_scheduler.sv
// Bench for cordic_channel_scheduler: stub delay-line CORDIC, a queue-based
// reference model, per-cycle comparison, directed scenarios and random traffic.
module tb_cordic_channel_scheduler;
  localparam int NCH = 4;
  localparam int IW  = 12;
  localparam int PW  = 19;
  localparam int OW  = 12;
  localparam int LAT = 17;
  localparam int CHW = $clog2(NCH);
  localparam int IFW = $clog2(LAT + 2);

  logic              clk = 1'b0;
  logic              rst, stall;
  logic [NCH-1:0]    req_valid, req_ready;
  logic [NCH*IW-1:0] req_x, req_y;
  logic [NCH*PW-1:0] req_phase;
  logic              cordic_ce;
  logic [IW-1:0]     cordic_x, cordic_y;
  logic [PW-1:0]     cordic_phase;
  logic [OW-1:0]     cin_x, cin_y;
  logic              res_valid;
  logic [CHW-1:0]    res_ch;
  logic [OW-1:0]     res_x, res_y;
  logic [IFW-1:0]    inflight;

  always #5 clk = ~clk;

  cordic_channel_scheduler #(.NCH(NCH), .IW(IW), .PW(PW), .OW(OW), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset(rst), .i_stall(stall),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_x(req_x), .i_req_y(req_y), .i_req_phase(req_phase),
    .o_cordic_ce(cordic_ce), .o_cordic_x(cordic_x), .o_cordic_y(cordic_y),
    .o_cordic_phase(cordic_phase),
    .i_cordic_x(cin_x), .i_cordic_y(cin_y),
    .o_res_valid(res_valid), .o_res_ch(res_ch), .o_res_x(res_x), .o_res_y(res_y),
    .o_inflight(inflight)
  );

  // Stub CORDIC: samples operands on ce edges, result after LAT ce edges.
  // y picks up the low phase bits so a lost phase is visible in the result.
  logic [OW-1:0] sx [LAT];
  logic [OW-1:0] sy [LAT];
  always @(posedge clk) begin
    if (cordic_ce) begin
      sx[0] <= cordic_x;
      sy[0] <= cordic_y + cordic_phase[OW-1:0];
      for (int k = 1; k < LAT; k++) begin
        sx[k] <= sx[k-1];
        sy[k] <= sy[k-1];
      end
    end
  end
  assign cin_x = sx[LAT-1];
  assign cin_y = sy[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          ch;
    logic [OW-1:0] x;
    logic [OW-1:0] y;
  } op_t;

  op_t           q[$];
  int            m_ptr = NCH - 1;
  int            m_ucnt = 0;
  logic          m_rv = 1'b0;
  int            m_rch = 0;
  logic [OW-1:0] m_rx = '0, m_ry = '0;
  logic [IW-1:0] m_cx = '0, m_cy = '0;
  logic [PW-1:0] m_cph = '0;
  bit            armed = 1'b0;

  int total = 0;
  int bad   = 0;

  int act_grant, act_strobe, act_inflight;
  logic [OW-1:0] act_rx;

  function automatic int pick(input logic [NCH-1:0] v, input logic s, input logic r);
    int idx;
    if (s || r) return -1;
    for (int i = 1; i <= NCH; i++) begin
      idx = (m_ptr + i) % NCH;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare everything at the falling edge,
  // then advance the model across the rising edge.
  task automatic step(input logic [NCH-1:0] v, input logic s, input logic r);
    int g;
    logic [NCH-1:0] exp_rdy;
    op_t op;
    req_valid = v; stall = s; rst = r;
    for (int k = 0; k < NCH; k++) begin
      req_x[k*IW +: IW]     = IW'($urandom);
      req_y[k*IW +: IW]     = IW'($urandom);
      req_phase[k*PW +: PW] = PW'($urandom);
    end
    @(negedge clk);
    g = pick(v, s, r);
    exp_rdy = (g >= 0) ? NCH'(1 << g) : '0;
    act_grant = -1;
    for (int k = NCH - 1; k >= 0; k--) if (req_ready[k]) act_grant = k;
    act_strobe   = res_valid ? int'(res_ch) : -1;
    act_inflight = int'(inflight);
    act_rx       = res_x;
    if (armed) begin
      chk("ready",     32'(req_ready),    32'(exp_rdy));
      chk("ce",        32'(cordic_ce),    32'(!s));
      chk("res_valid", 32'(res_valid),    32'(m_rv));
      chk("res_ch",    32'(res_ch),       32'(m_rch));
      chk("res_x",     32'(res_x),        32'(m_rx));
      chk("res_y",     32'(res_y),        32'(m_ry));
      chk("inflight",  32'(inflight),     32'(q.size()));
      chk("cordic_x",  32'(cordic_x),     32'(m_cx));
      chk("cordic_y",  32'(cordic_y),     32'(m_cy));
      chk("cordic_ph", 32'(cordic_phase), 32'(m_cph));
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ptr = NCH - 1; m_rv = 1'b0; m_rch = 0; m_rx = '0; m_ry = '0;
      m_cx = '0; m_cy = '0; m_cph = '0;
      armed = 1'b1;
    end else if (s) begin
      m_rv = 1'b0;
    end else begin
      m_ucnt++;
      m_rv = 1'b0;
      if (q.size() > 0 && q[0].due == m_ucnt) begin
        op = q.pop_front();
        m_rv = 1'b1; m_rch = op.ch; m_rx = op.x; m_ry = op.y;
      end
      if (g >= 0) begin
        op.due = m_ucnt + LAT + 1;
        op.ch  = g;
        op.x   = req_x[g*IW +: IW];
        op.y   = req_y[g*IW +: IW] + req_phase[g*PW +: OW];
        q.push_back(op);
        m_ptr = g;
        m_cx  = req_x[g*IW +: IW];
        m_cy  = req_y[g*IW +: IW];
        m_cph = req_phase[g*PW +: PW];
      end else begin
        m_cx = '0; m_cy = '0; m_cph = '0;
      end
    end
    #1;
  endtask

  initial begin
    int n, peak, cnt, first;
    bit ok;
    logic [IW-1:0] sent_x;
    int seq[$];

    // Reset and idle state.
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    chk("rst_inflight", 32'(act_inflight), 32'(0));
    chk("rst_valid", 32'(act_strobe), 32'(-1));

    // Single channel 2: strobe appears in the cycle after the 18th edge.
    req_x[2*IW +: IW] = 12'h100;
    step(4'b0100, 1'b0, 1'b0);
    chk("single_grant", 32'(act_grant), 32'(2));
    sent_x = m_cx;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      step('0, 1'b0, 1'b0);
      n++;
      if (act_strobe >= 0) break;
    end
    chk("single_latency", 32'(n), 32'(LAT + 2));
    chk("single_ch", 32'(act_strobe), 32'(2));
    chk("single_x", 32'(act_rx), 32'(sent_x));

    // All four channels valid: grants 0,1,2,3 repeating, results in order.
    step('0, 1'b0, 1'b1);
    ok = 1'b1; peak = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'hf, 1'b0, 1'b0);
      if (act_grant != i % NCH) ok = 1'b0;
    end
    chk("fair_order", 32'(ok), 32'(1));
    seq.delete();
    for (int i = 0; i < 30; i++) begin
      step('0, 1'b0, 1'b0);
      if (act_inflight > peak) peak = act_inflight;
      if (act_strobe >= 0) seq.push_back(act_strobe);
    end
    chk("fair_peak", 32'(peak), 32'(16));
    chk("fair_count", 32'(seq.size()), 32'(16));
    ok = 1'b1;
    foreach (seq[i]) if (seq[i] != i % NCH) ok = 1'b0;
    chk("fair_res_order", 32'(ok), 32'(1));

    // Stall for 5 cycles with 3 in flight: strobes shift by exactly 5.
    step('0, 1'b0, 1'b1);
    first = -1; cnt = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      if (i < 3)                step(4'b0010, 1'b0, 1'b0);
      else if (i >= 7 && i < 12) step(4'hf, 1'b1, 1'b0);
      else                      step('0, 1'b0, 1'b0);
      if (i >= 7 && i < 12 && (act_grant >= 0 || act_strobe >= 0)) cnt++;
      if (act_strobe >= 0) begin
        n++;
        if (first < 0) first = i;
      end
    end
    chk("stall_quiet", 32'(cnt), 32'(0));
    chk("stall_first", 32'(first), 32'(LAT + 2 + 5));
    chk("stall_count", 32'(n), 32'(3));

    // Reset with 10 in flight: nothing returns, next grant to channel 0.
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'hf, 1'b0, 1'b0);
    step(4'hf, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step('0, 1'b0, 1'b0);
      if (act_strobe >= 0) cnt++;
    end
    chk("rstmid_strobes", 32'(cnt), 32'(0));
    chk("rstmid_inflight", 32'(act_inflight), 32'(0));
    step(4'hf, 1'b0, 1'b0);
    chk("rstmid_grant", 32'(act_grant), 32'(0));

    // Saturation: accept and return on the same edge keep the count at LAT+1.
    step('0, 1'b0, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(4'b1000, 1'b0, 1'b0);
      if (act_grant != 3) ok = 1'b0;
      if (i >= 19 && act_inflight != LAT + 1) ok = 1'b0;
    end
    chk("sat_steady", 32'(ok), 32'(1));

    // Skip and idle: ptr stays on channel 1 through idle cycles.
    step('0, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    chk("idle_ptr_hold", 32'(act_grant), 32'(0));
    step(4'b1010, 1'b0, 1'b0);
    chk("skip_grant", 32'(act_grant), 32'(1));

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 500; i++)
      step(NCH'($urandom), ($urandom % 6) == 0, ($urandom % 80) == 0);
    for (int i = 0; i < 25; i++) step('0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
